// File: rtl/message_scroller_pkg.sv
// Shared definitions for the scrolling four-digit seven-segment character path:
// anode strobe patterns, digit index type, boot message and commit FSM encoding.
package message_scroller_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t     DIG_AN0  = 2'd3;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Indexed by digit: an3 first, an0 last; bit order is {an3, an2, an1, an0}.
    localparam logic [3:0] AN_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Entry i lives at bits [4i +: 4], giving "0123456789ABCDEF".
    localparam logic [63:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

    typedef enum logic {
        CS_IDLE    = 1'b0,
        CS_PENDING = 1'b1
    } commit_state_t;

    function automatic logic [3:0] an_pattern(input digit_t d);
        return AN_PATTERN[d];
    endfunction

    function automatic logic [3:0] reset_nibble(input int i);
        return RESET_MSG[4*i +: 4];
    endfunction

endpackage

// File: rtl/message_scroller_digit_scan.sv
// Digit multiplex timer: holds each digit for SCAN_DIV cycles, walks an3..an0,
// and flags the last cycle of every an0 period as the frame boundary.
module digit_scan_timer
    import message_scroller_pkg::*;
#(
    parameter int SCAN_DIV = 800
) (
    input  logic   clk,
    input  logic   reset,
    output digit_t next_dig,
    output logic   frame_end
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic          running;
    logic [CW-1:0] cnt;
    digit_t        dig;
    logic          last_cnt;

    assign last_cnt  = (cnt == CNT_LAST);
    assign frame_end = running && last_cnt && (dig == DIG_AN0);

    // The display registers load from next_dig, so the first post-reset edge lights an3.
    always_comb begin
        next_dig = dig;
        if (running && last_cnt) begin
            next_dig = digit_t'(dig + 2'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            dig     <= '0;
        end else begin
            running <= 1'b1;
            dig     <= next_dig;
            if (running) begin
                cnt <= last_cnt ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/message_scroller.sv
// Double-buffered 16-nibble message source for the seven-segment display:
// scans four consecutive nibbles onto the anodes and scrolls the window per frame count.
module message_scroller
    import message_scroller_pkg::*;
#(
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 800,
    parameter int SCROLL_FRAMES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       commit,
    output logic       commit_pending,
    input  logic       pause,
    output logic [3:0] char,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic [3:0] scroll_pos
);

    localparam int            FW         = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [3:0]    IDX_MASK   = 4'(MSG_LEN - 1);

    commit_state_t state;
    logic [3:0]    active_buf [MSG_LEN];
    logic [3:0]    shadow_buf [MSG_LEN];
    logic [FW-1:0] frame_cnt;
    digit_t        next_dig;
    logic          frame_end;
    logic          apply_commit;
    logic          scroll_step;
    logic          wr_accept;
    logic [3:0]    pos_next;
    logic [3:0]    char_next;

    digit_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .next_dig  (next_dig),
        .frame_end (frame_end)
    );

    function automatic logic [3:0] msg_index(input logic [3:0] base, input digit_t d);
        return (base + {2'b00, d}) & IDX_MASK;
    endfunction

    assign wr_accept    = wr_en && wr_ready;
    assign apply_commit = frame_end && (state == CS_PENDING);
    assign scroll_step  = frame_end && (frame_cnt == FRAME_LAST) && !pause;

    // On the applying edge the shadow is read directly so new content shows without a lag cycle.
    always_comb begin
        pos_next  = scroll_pos;
        char_next = active_buf[msg_index(scroll_pos, next_dig)];
        if (apply_commit) begin
            pos_next  = '0;
            char_next = shadow_buf[msg_index(4'd0, next_dig)];
        end else if (scroll_step) begin
            pos_next  = msg_index(scroll_pos, 2'd1);
            char_next = active_buf[msg_index(pos_next, next_dig)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= CS_IDLE;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
        end else begin
            case (state)
                CS_IDLE: begin
                    if (commit) begin
                        state          <= CS_PENDING;
                        commit_pending <= 1'b1;
                        wr_ready       <= 1'b0;
                    end
                end
                CS_PENDING: begin
                    if (frame_end) begin
                        state          <= CS_IDLE;
                        commit_pending <= 1'b0;
                        wr_ready       <= 1'b1;
                    end
                end
                default: begin
                    state          <= CS_IDLE;
                    commit_pending <= 1'b0;
                    wr_ready       <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                active_buf[i] <= reset_nibble(i);
                shadow_buf[i] <= reset_nibble(i);
            end
        end else begin
            if (wr_accept) begin
                shadow_buf[wr_addr] <= wr_data;
            end
            if (apply_commit) begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    active_buf[i] <= shadow_buf[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt            <= '0;
            scroll_pos           <= '0;
            char                 <= '0;
            {an3, an2, an1, an0} <= AN_BLANK;
        end else begin
            if (apply_commit) begin
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
            end
            scroll_pos           <= pos_next;
            char                 <= char_next;
            {an3, an2, an1, an0} <= an_pattern(next_dig);
        end
    end

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: time-based reference model checked every cycle,
// directed literal checkpoints, then randomized writes/commits/pause.
module tb_message_scroller;

    localparam int SD = 4;
    localparam int SF = 2;
    localparam int ML = 16;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       commit;
    logic       commit_pending;
    logic       pause;
    logic [3:0] char;
    logic       an3, an2, an1, an0;
    logic [3:0] scroll_pos;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edges since reset release, buffers, window position.
    int ecount = 0;
    int m_active [ML];
    int m_shadow [ML];
    int m_pos;
    int m_frames;
    bit m_pend;
    bit m_bnd;
    bit m_was_pend;

    message_scroller #(
        .MSG_LEN       (ML),
        .SCAN_DIV      (SD),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .commit_pending (commit_pending),
        .pause          (pause),
        .char           (char),
        .an3            (an3),
        .an2            (an2),
        .an1            (an1),
        .an0            (an0),
        .scroll_pos     (scroll_pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    function automatic int anodes();
        return int'({an3, an2, an1, an0});
    endfunction

    // Digit shown after edge e is ((e-1)/SD)%4; a frame closes every 4*SD edges.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecount = 0;
            for (int i = 0; i < ML; i++) begin
                m_active[i] = i;
                m_shadow[i] = i;
            end
            m_pos    = 0;
            m_frames = 0;
            m_pend   = 1'b0;
        end else begin
            ecount++;
            m_bnd      = (ecount > 1) && (((ecount - 1) % (4 * SD)) == 0);
            m_was_pend = m_pend;
            if (m_bnd) begin
                if (m_was_pend) begin
                    m_active = m_shadow;
                    m_pos    = 0;
                    m_frames = 0;
                    m_pend   = 1'b0;
                end else begin
                    m_frames++;
                    if (m_frames == SF) begin
                        m_frames = 0;
                        if (!pause) m_pos = (m_pos + 1) % ML;
                    end
                end
            end
            if (!m_was_pend && wr_en) m_shadow[wr_addr] = int'(wr_data);
            if (!m_was_pend && commit) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        int d;
        logic [3:0] exp_an;
        if (reset || ecount == 0) begin
            chk("rst_anodes", anodes(), 15);
            chk("rst_char", int'(char), 0);
            chk("rst_scroll_pos", int'(scroll_pos), 0);
            chk("rst_commit_pending", int'(commit_pending), 0);
            chk("rst_wr_ready", int'(wr_ready), 1);
        end else begin
            d      = ((ecount - 1) / SD) % 4;
            exp_an = 4'b1111 ^ (4'b1000 >> d);
            chk("anodes", anodes(), int'(exp_an));
            chk("char", int'(char), m_active[(m_pos + d) % ML]);
            chk("scroll_pos", int'(scroll_pos), m_pos);
            chk("commit_pending", int'(commit_pending), int'(m_pend));
            chk("wr_ready", int'(wr_ready), int'(!m_pend));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (ecount < target && guard < 5000) begin
            step();
            guard++;
        end
        chk("run_to_edge", ecount, target);
    endtask

    task automatic lit(input int edge_n, input int exp_an, input int exp_char, input int exp_pos);
        run_to(edge_n);
        chk("lit_anodes", anodes(), exp_an);
        chk("lit_char", int'(char), exp_char);
        chk("lit_scroll_pos", int'(scroll_pos), exp_pos);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 4'd0;
        commit  = 1'b0;
        pause   = 1'b0;
        #1 reset = 1'b1;
        repeat (3) begin
            step();
            chk("hold_rst_anodes", anodes(), 4'hF);
            chk("hold_rst_char", int'(char), 0);
        end
        reset = 1'b0;

        // First frame and first scroll step.
        lit(1, 4'b0111, 0, 0);
        lit(5, 4'b1011, 1, 0);
        lit(9, 4'b1101, 2, 0);
        lit(13, 4'b1110, 3, 0);
        lit(32, 4'b1110, 3, 0);
        lit(33, 4'b0111, 1, 1);
        lit(37, 4'b1011, 2, 1);
        lit(45, 4'b1110, 4, 1);

        // Window near the end of the message and the wrap to 0.
        lit(417, 4'b0111, 13, 13);
        lit(421, 4'b1011, 14, 13);
        lit(425, 4'b1101, 15, 13);
        lit(429, 4'b1110, 0, 13);
        lit(449, 4'b0111, 14, 14);
        lit(461, 4'b1110, 1, 14);
        lit(481, 4'b0111, 15, 15);
        lit(513, 4'b0111, 0, 0);

        // Pause across three scroll periods.
        pause = 1'b1;
        lit(546, 4'b0111, 0, 0);
        lit(578, 4'b0111, 0, 0);
        lit(612, 4'b0111, 0, 0);
        pause = 1'b0;
        lit(640, 4'b1110, 3, 0);
        lit(641, 4'b0111, 1, 1);

        // Write and commit together, then a dropped write while pending.
        run_to(643);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd5; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        chk("pend_commit_pending", int'(commit_pending), 1);
        chk("pend_wr_ready", int'(wr_ready), 0);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'd9;
        step();
        wr_en = 1'b0;
        run_to(656);
        chk("pend_before_boundary", int'(commit_pending), 1);
        lit(657, 4'b0111, 5, 0);
        chk("applied_commit_pending", int'(commit_pending), 0);
        chk("applied_wr_ready", int'(wr_ready), 1);
        lit(661, 4'b1011, 1, 0);
        lit(665, 4'b1101, 2, 0);
        lit(669, 4'b1110, 3, 0);

        // Randomized traffic checked by the model every cycle.
        repeat (1500) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            commit  = ($urandom_range(0, 60) == 0);
            pause   = ($urandom_range(0, 5) == 0);
            step();
        end
        wr_en = 1'b0; commit = 1'b0; pause = 1'b0;
        repeat (40) step();

        // Reset while a commit is pending.
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("pre_reset_pending", int'(commit_pending), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_anodes", anodes(), 4'hF);
        chk("async_rst_char", int'(char), 0);
        chk("async_rst_pending", int'(commit_pending), 0);
        chk("async_rst_wr_ready", int'(wr_ready), 1);
        chk("async_rst_pos", int'(scroll_pos), 0);
        step();
        step();
        reset = 1'b0;
        lit(1, 4'b0111, 0, 0);
        lit(5, 4'b1011, 1, 0);
        lit(9, 4'b1101, 2, 0);
        lit(13, 4'b1110, 3, 0);
        lit(20, 4'b0111, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
